// File: rtl/sobel_window_mag.sv
// Streaming 3x3 Sobel edge detector: shifts pixel columns into a window, then
// computes the saturated |Gx|+|Gy| magnitude and an edge flag in two stages.
module sobel_window_mag #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 128,
  parameter int THRESHOLD  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [DATA_WIDTH-1:0]        row0,
  input  logic [DATA_WIDTH-1:0]        row1,
  input  logic [DATA_WIDTH-1:0]        row2,
  input  logic                         rows_valid,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         is_edge,
  output logic [$clog2(IMG_WIDTH)-1:0] out_col
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int GW    = DATA_WIDTH + 3;
  localparam logic [DATA_WIDTH-1:0] THR = DATA_WIDTH'(THRESHOLD);

  logic [DATA_WIDTH-1:0] r_win [3][3];
  logic [COL_W-1:0]      r_col;
  logic                  r_wvalid;
  logic [COL_W-1:0]      r_wcol;

  logic signed [GW-1:0]  r_gx;
  logic signed [GW-1:0]  r_gy;
  logic                  r_v1;
  logic [COL_W-1:0]      r_col1;

  logic signed [GW-1:0]  w_gx;
  logic signed [GW-1:0]  w_gy;
  logic [GW-1:0]         w_absGx;
  logic [GW-1:0]         w_absGy;
  logic [GW-1:0]         w_mag;
  logic [DATA_WIDTH-1:0] w_sat;

  function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
    return {3'b000, v};
  endfunction

  // Window only valid once three columns of the current row have been seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          r_win[r][c] <= '0;
      r_col    <= '0;
      r_wvalid <= 1'b0;
      r_wcol   <= '0;
    end else if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= row0;
      r_win[1][2] <= row1;
      r_win[2][2] <= row2;
      r_wvalid    <= rows_valid && (r_col >= COL_W'(2));
      r_wcol      <= r_col - COL_W'(1);
      r_col       <= (r_col == COL_W'(IMG_WIDTH - 1)) ? '0 : r_col + COL_W'(1);
    end else begin
      r_wvalid <= 1'b0;
    end
  end

  assign w_gx = (ext(r_win[0][2]) + ext(r_win[1][2]) + ext(r_win[1][2]) + ext(r_win[2][2]))
              - (ext(r_win[0][0]) + ext(r_win[1][0]) + ext(r_win[1][0]) + ext(r_win[2][0]));
  assign w_gy = (ext(r_win[2][0]) + ext(r_win[2][1]) + ext(r_win[2][1]) + ext(r_win[2][2]))
              - (ext(r_win[0][0]) + ext(r_win[0][1]) + ext(r_win[0][1]) + ext(r_win[0][2]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gx   <= '0;
      r_gy   <= '0;
      r_v1   <= 1'b0;
      r_col1 <= '0;
    end else begin
      r_gx   <= w_gx;
      r_gy   <= w_gy;
      r_v1   <= r_wvalid;
      r_col1 <= r_wcol;
    end
  end

  // |G| of an 8-bit Sobel never exceeds 2040, so GW bits hold the sum exactly.
  assign w_absGx = r_gx[GW-1] ? -r_gx : r_gx;
  assign w_absGy = r_gy[GW-1] ? -r_gy : r_gy;
  assign w_mag   = w_absGx + w_absGy;
  assign w_sat   = (|w_mag[GW-1:DATA_WIDTH]) ? '1 : w_mag[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      is_edge   <= 1'b0;
      out_col   <= '0;
    end else begin
      out_valid <= r_v1;
      dout      <= w_sat;
      is_edge   <= (w_sat >= THR);
      out_col   <= r_col1;
    end
  end

endmodule

// File: tb/tb_sobel_window_mag.sv
// Randomized and directed bench for sobel_window_mag against a column-history
// reference model that recomputes each expected Sobel window with plain integers.
module tb_sobel_window_mag;

  localparam int DW  = 8;
  localparam int IW  = 128;
  localparam int THR = 64;

  logic       clk;
  logic       rst_n;
  logic       validIn;
  logic [7:0] row0, row1, row2;
  logic       rowsValid;
  logic       outValid;
  logic [7:0] dout;
  logic       isEdge;
  logic [6:0] outCol;

  sobel_window_mag #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .THRESHOLD(THR)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(validIn),
    .row0(row0), .row1(row1), .row2(row2), .rows_valid(rowsValid),
    .out_valid(outValid), .dout(dout), .is_edge(isEdge), .out_col(outCol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int dout;
    int col;
  } exp_t;

  exp_t expQ[$];
  int   win[3][3];
  int   mCol;
  int   cyc;
  int   pushCount;
  int   nChecks;
  int   nFails;

  int outCount, firstCyc, firstCol, lastCol, satCount, nonZero, rampCnt, cnt40, startCyc;

  task automatic checkOutput(input string name, input int got, input int expv);
    nChecks++;
    if (got != expv) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Reference Sobel magnitude of the current model window, straight from the kernel sums.
  function automatic int refMag();
    int gx, gy, mag;
    gx = (win[0][2] + 2 * win[1][2] + win[2][2]) - (win[0][0] + 2 * win[1][0] + win[2][0]);
    gy = (win[2][0] + 2 * win[2][1] + win[2][2]) - (win[0][0] + 2 * win[0][1] + win[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > 255) ? 255 : mag;
  endfunction

  task automatic clearWin();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][c] = 0;
  endtask

  task automatic applyStimulus(input logic v, input int r0, input int r1, input int r2,
                               input logic rv);
    exp_t e;
    #1;
    validIn   = v;
    row0      = r0[7:0];
    row1      = r1[7:0];
    row2      = r2[7:0];
    rowsValid = rv;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mCol = 0;
      clearWin();
    end else if (v) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] = win[r][1];
        win[r][1] = win[r][2];
      end
      win[0][2] = r0 & 255;
      win[1][2] = r1 & 255;
      win[2][2] = r2 & 255;
      if (rv && mCol >= 2) begin
        e.due  = cyc + 2;
        e.dout = refMag();
        e.col  = mCol - 1;
        expQ.push_back(e);
        pushCount++;
      end
      mCol = (mCol + 1) % IW;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic resetStats();
    outCount = 0; firstCyc = -1; firstCol = -1; lastCol = -1;
    satCount = 0; nonZero = 0; rampCnt = 0; cnt40 = 0;
    startCyc = cyc;
  endtask

  // Single compare process: every negedge the DUT must match the model exactly.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checkOutput("rst_out_valid", int'(outValid), 0);
      checkOutput("rst_dout", int'(dout), 0);
      checkOutput("rst_edge", int'(isEdge), 0);
      checkOutput("rst_out_col", int'(outCol), 0);
    end else if (expQ.size() > 0 && expQ[0].due == cyc) begin
      e = expQ.pop_front();
      checkOutput("out_valid", int'(outValid), 1);
      checkOutput("dout", int'(dout), e.dout);
      checkOutput("edge", int'(isEdge), (e.dout >= THR) ? 1 : 0);
      checkOutput("out_col", int'(outCol), e.col);
    end else begin
      checkOutput("idle_out_valid", int'(outValid), 0);
    end
    if (outValid) begin
      outCount++;
      if (firstCyc < 0) begin
        firstCyc = cyc;
        firstCol = int'(outCol);
      end
      lastCol = int'(outCol);
      if (dout == 8'd255) satCount++;
      if (dout != 8'd0) nonZero++;
      if (dout == 8'd80 && isEdge && outCol >= 7'd1 && outCol <= 7'd24) rampCnt++;
      if (dout == 8'd40 && !isEdge) cnt40++;
    end
  end

  initial begin
    int vc, flushed, pushBase, p;
    logic v, rv;
    nChecks = 0; nFails = 0; cyc = 0; mCol = 0; pushCount = 0;
    rst_n = 1'b0; validIn = 1'b0; row0 = '0; row1 = '0; row2 = '0; rowsValid = 1'b0;
    resetStats();

    // Pin the reference model on hand-computed windows.
    clearWin();
    for (int r = 0; r < 3; r++) begin win[r][1] = 255; win[r][2] = 255; end
    checkOutput("model_vstep", refMag(), 255);
    clearWin();
    for (int c = 0; c < 3; c++) win[2][c] = 10;
    checkOutput("model_hstep40", refMag(), 40);
    clearWin();

    idle(3);
    #2 rst_n = 1'b1;

    $display("[TB] uniform image");
    resetStats();
    for (int c = 0; c < IW; c++) applyStimulus(1'b1, 50, 50, 50, 1'b1);
    idle(3);
    checkOutput("uniform_count", outCount, IW - 2);
    checkOutput("uniform_latency", firstCyc - startCyc, 5);
    checkOutput("uniform_first_col", firstCol, 1);
    checkOutput("uniform_nonzero", nonZero, 0);

    $display("[TB] horizontal ramp");
    resetStats();
    for (int c = 0; c < IW; c++) begin
      p = (10 * c) & 255;
      applyStimulus(1'b1, p, p, p, 1'b1);
    end
    idle(3);
    checkOutput("ramp_count", outCount, IW - 2);
    checkOutput("ramp_first_col", firstCol, 1);
    checkOutput("ramp_last_col", lastCol, IW - 2);
    checkOutput("ramp_80_edges", rampCnt, 24);

    $display("[TB] vertical step");
    resetStats();
    for (int c = 0; c < IW; c++) begin
      p = (c < 64) ? 0 : 255;
      applyStimulus(1'b1, p, p, p, 1'b1);
    end
    idle(3);
    checkOutput("vstep_saturated", satCount, 2);
    checkOutput("vstep_nonzero", nonZero, 2);

    $display("[TB] horizontal steps");
    resetStats();
    for (int c = 0; c < IW; c++) applyStimulus(1'b1, 0, 200, 200, 1'b1);
    idle(3);
    checkOutput("hstep800_saturated", satCount, IW - 2);
    resetStats();
    for (int c = 0; c < IW; c++) applyStimulus(1'b1, 0, 0, 10, 1'b1);
    idle(3);
    checkOutput("hstep40_count", cnt40, IW - 2);

    $display("[TB] random pixels with rows_valid gating and valid gaps");
    resetStats();
    pushBase = pushCount;
    vc = 0;
    while (vc < 4 * IW) begin
      v  = ($urandom_range(0, 3) != 0);
      rv = (vc < 2 * IW) ? 1'b0 : ((vc >= 300 && vc < 310) ? 1'b0 : 1'b1);
      applyStimulus(v, $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), rv);
      if (v) vc++;
    end
    idle(3);
    checkOutput("random_count_vs_model", outCount, pushCount - pushBase);
    checkOutput("random_count", outCount, 2 * (IW - 2) - 10);

    $display("[TB] reset with results in flight");
    for (int c = 0; c < 5; c++)
      applyStimulus(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    flushed = expQ.size();
    expQ.delete();
    mCol = 0;
    clearWin();
    #1;
    checkOutput("reset_inflight", flushed, 2);
    checkOutput("reset_kills_valid", int'(outValid), 0);
    applyStimulus(1'b1, 7, 8, 9, 1'b1);
    applyStimulus(1'b1, 7, 8, 9, 1'b1);
    #2 rst_n = 1'b1;
    resetStats();
    for (int c = 0; c < 8; c++)
      applyStimulus(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(0, 255), 1'b1);
    idle(3);
    checkOutput("post_reset_latency", firstCyc - startCyc, 5);
    checkOutput("post_reset_first_col", firstCol, 1);
    checkOutput("post_reset_count", outCount, 6);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
